// File: rtl/neonfox_irq_pkg.sv
// NeonFox interrupt controller shared definitions.
// Register offsets, FSM state type and gap counter sizing.
package neonfox_irq_pkg;

    localparam logic [2:0] REG_PEND = 3'd0;
    localparam logic [2:0] REG_MASK = 3'd1;
    localparam logic [2:0] REG_STAT = 3'd2;
    localparam logic [2:0] REG_EOI  = 3'd3;
    localparam logic [2:0] REG_SWI  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_t;

    // Counter holds GAP_CYC-1 down to 0.
    function automatic int gap_cnt_w(input int gap_cyc);
        return (gap_cyc <= 2) ? 1 : $clog2(gap_cyc);
    endfunction

endpackage

// File: rtl/neonfox_irq_if.sv
// NeonFox CPU IO bus as seen by the interrupt controller.
// master = CPU side, slave = peripheral side.
interface neonfox_irq_if;

    logic [15:0] IO_address;
    logic        IO_wren;
    logic        IO_ren;
    logic        H_en;
    logic        L_en;
    logic [15:0] data_in;
    logic [15:0] io_rdata;

    modport master (
        output IO_address,
        output IO_wren,
        output IO_ren,
        output H_en,
        output L_en,
        output data_in,
        input  io_rdata
    );

    modport slave (
        input  IO_address,
        input  IO_wren,
        input  IO_ren,
        input  H_en,
        input  L_en,
        input  data_in,
        output io_rdata
    );

endinterface

// File: rtl/neonfox_irq_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder for the interrupt candidates.
// Index 0 has the highest priority.
module irq_prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0] vec,
    output logic [3:0]   idx,
    output logic         vld
);

    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/neonfox_irq_ctrl.sv
// NeonFox interrupt controller: edge latch, mask, priority select,
// and a REQ/GAP handshake driving the CPU int_rq/int_addr pins.
module neonfox_irq_ctrl
    import neonfox_irq_pkg::*;
#(
    parameter int          NUM_SRC   = 16,
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          GAP_CYC   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    neonfox_irq_if.slave       io,
    output logic               int_rq,
    output logic [3:0]         int_addr
);

    localparam int GW = gap_cnt_w(GAP_CYC);
    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

    logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
    logic [15:0]        pend_q, pend_d;
    logic [15:0]        mask_q, mask_d;
    irq_state_t         state_q, state_d;
    logic               int_rq_q, int_rq_d;
    logic               in_svc_q, in_svc_d;
    logic [3:0]         cur_vec_q, cur_vec_d;
    logic [GW-1:0]      gap_q, gap_d;

    logic [15:0] off;
    logic        hit;
    logic [2:0]  reg_sel;
    logic [15:0] wbe;
    logic        wr_pend, wr_mask, wr_eoi, wr_swi;
    logic [15:0] edges, cand, pend_clr, swi_set;
    logic [3:0]  sel_idx;
    logic        sel_vld;
    logic        take;

    assign off     = io.IO_address - BASE_ADDR;
    assign hit     = (io.IO_address >= BASE_ADDR) && (off < 16'd5);
    assign reg_sel = off[2:0];

    // No lane enable at all is the CPU's encoding for a full word.
    assign wbe = (io.H_en | io.L_en)
               ? {{8{io.H_en}}, {8{io.L_en}}} : 16'hFFFF;

    assign wr_pend = io.IO_wren && hit && (reg_sel == REG_PEND);
    assign wr_mask = io.IO_wren && hit && (reg_sel == REG_MASK);
    assign wr_eoi  = io.IO_wren && hit && (reg_sel == REG_EOI);
    assign wr_swi  = io.IO_wren && hit && (reg_sel == REG_SWI);

    assign edges   = 16'(irq_src & ~src_prev_q);
    assign cand    = pend_q & mask_q & SRC_MASK;
    assign swi_set = wr_swi ? (io.data_in & wbe) : 16'h0000;

    irq_prio_enc #(
        .N(NUM_SRC)
    ) u_prio (
        .vec(cand[NUM_SRC-1:0]),
        .idx(sel_idx),
        .vld(sel_vld)
    );

    always_comb begin
        state_d   = state_q;
        int_rq_d  = int_rq_q;
        in_svc_d  = in_svc_q;
        cur_vec_d = cur_vec_q;
        gap_d     = gap_q;
        take      = 1'b0;
        unique case (state_q)
            IDLE: begin
                take = sel_vld;
            end
            REQ: begin
                if (wr_eoi) begin
                    state_d  = GAP;
                    int_rq_d = 1'b0;
                    in_svc_d = 1'b0;
                    gap_d    = GW'(GAP_CYC - 1);
                end
            end
            GAP: begin
                // Last gap cycle doubles as the IDLE evaluation.
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    take    = sel_vld;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take) begin
            state_d   = REQ;
            int_rq_d  = 1'b1;
            in_svc_d  = 1'b1;
            cur_vec_d = sel_idx;
        end
    end

    always_comb begin
        pend_clr = 16'h0000;
        if (wr_pend) begin
            pend_clr = io.data_in & wbe;
        end
        if (take) begin
            pend_clr = pend_clr | (16'h0001 << sel_idx);
        end
        // New events win over any clear in the same cycle.
        pend_d = ((pend_q & ~pend_clr) | edges | swi_set) & SRC_MASK;
    end

    always_comb begin
        mask_d = mask_q;
        if (wr_mask) begin
            mask_d = ((mask_q & ~wbe) | (io.data_in & wbe)) & SRC_MASK;
        end
    end

    assign src_prev_d = irq_src;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_prev_q <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
        end else begin
            src_prev_q <= src_prev_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            int_rq_q  <= 1'b0;
            in_svc_q  <= 1'b0;
            cur_vec_q <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            int_rq_q  <= int_rq_d;
            in_svc_q  <= in_svc_d;
            cur_vec_q <= cur_vec_d;
            gap_q     <= gap_d;
        end
    end

    assign int_rq   = int_rq_q;
    assign int_addr = cur_vec_q;

    always_comb begin
        io.io_rdata = 16'h0000;
        if (io.IO_ren && hit) begin
            unique case (reg_sel)
                REG_PEND: io.io_rdata = pend_q;
                REG_MASK: io.io_rdata = mask_q;
                REG_STAT: io.io_rdata = {in_svc_q, 11'b0, cur_vec_q};
                default:  io.io_rdata = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_neonfox_irq_ctrl.sv
// Scoreboard bench for neonfox_irq_ctrl: expected reads and
// interrupt vectors are queued by stimulus and checked by a monitor.
module tb_neonfox_irq_ctrl;
    import neonfox_irq_pkg::*;

    localparam int          NUM_SRC = 16;
    localparam logic [15:0] BASE    = 16'hFF00;
    localparam int          GAP     = 2;

    typedef struct {
        int vec;
        int cyc;
    } rise_t;

    logic               clk;
    logic               reset_n;
    logic [NUM_SRC-1:0] irq_src;
    logic               int_rq;
    logic [3:0]         int_addr;

    neonfox_irq_if io ();

    neonfox_irq_ctrl #(
        .NUM_SRC(NUM_SRC),
        .BASE_ADDR(BASE),
        .GAP_CYC(GAP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .irq_src(irq_src),
        .io(io),
        .int_rq(int_rq),
        .int_addr(int_addr)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        rq_prev = 1'b0;
    logic [15:0] rd_q[$];
    rise_t       rise_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    // Monitor: compares reads and each int_rq assertion.
    always @(negedge clk) begin
        if (io.IO_ren) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                chk("io_rdata", {16'h0, io.io_rdata}, {16'h0, rd_q[0]});
                void'(rd_q.pop_front());
            end
        end
        if (int_rq && !rq_prev) begin
            if (rise_q.size() == 0) begin
                chk("rq_unexpected", 32'd1, 32'd0);
            end else begin
                chk("int_addr", {28'h0, int_addr}, rise_q[0].vec);
                chk("rq_cycle", cyc, rise_q[0].cyc);
                void'(rise_q.pop_front());
            end
        end
        rq_prev <= int_rq;
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic io_write(logic [2:0] off, logic [15:0] d,
                            logic h = 1'b1, logic l = 1'b1);
        io.IO_address = BASE + 16'(off);
        io.data_in    = d;
        io.H_en       = h;
        io.L_en       = l;
        io.IO_wren    = 1'b1;
        tick();
        io.IO_wren    = 1'b0;
    endtask

    task automatic io_read(logic [2:0] off, logic [15:0] exp);
        io.IO_address = BASE + 16'(off);
        io.IO_ren     = 1'b1;
        rd_q.push_back(exp);
        tick();
        io.IO_ren     = 1'b0;
    endtask

    task automatic exp_rise(int vec, int at);
        rise_t r;
        r.vec = vec;
        r.cyc = at;
        rise_q.push_back(r);
    endtask

    task automatic wait_rise();
        for (int i = 0; i < 40 && rise_q.size() != 0; i++) tick();
        chk("rise_wait", rise_q.size(), 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        irq_src       = '0;
        io.IO_address = 16'h0000;
        io.IO_wren    = 1'b0;
        io.IO_ren     = 1'b0;
        io.H_en       = 1'b0;
        io.L_en       = 1'b0;
        io.data_in    = 16'h0000;
        tick(3);
        reset_n = 1'b1;
        tick();

        // 1: reset state, masked latch, unmask -> request
        io_read(REG_PEND, 16'h0000);
        io_read(REG_MASK, 16'h0000);
        io_read(REG_STAT, 16'h0000);
        chk("rst_int_rq", int_rq, 0);
        irq_src[3] = 1'b1;
        tick();
        irq_src[3] = 1'b0;
        tick();
        io_read(REG_PEND, 16'h0008);
        chk("masked_no_rq", int_rq, 0);
        exp_rise(3, cyc + 2);
        io_write(REG_MASK, 16'h0008);
        wait_rise();
        io_read(REG_PEND, 16'h0000);
        io_read(REG_STAT, 16'h8003);
        io_write(REG_EOI, 16'h0000);
        chk("eoi_drop", int_rq, 0);
        tick(4);

        // 2: priority and gap length
        io_write(REG_MASK, 16'hFFFF);
        exp_rise(2, cyc + 2);
        irq_src = 16'h0204;
        tick();
        irq_src = '0;
        wait_rise();
        io_read(REG_STAT, 16'h8002);
        io_read(REG_PEND, 16'h0200);
        exp_rise(9, cyc + GAP + 1);
        io_write(REG_EOI, 16'h1234);
        chk("gap_low1", int_rq, 0);
        tick();
        chk("gap_low2", int_rq, 0);
        wait_rise();
        io_read(REG_STAT, 16'h8009);
        io_write(REG_EOI, 16'h0000);
        tick(4);

        // 3: W1C colliding with a new edge
        io_write(REG_MASK, 16'h0000);
        irq_src[4] = 1'b1;
        io_write(REG_PEND, 16'h0010);
        io_read(REG_PEND, 16'h0010);
        io_write(REG_PEND, 16'h0010);
        io_read(REG_PEND, 16'h0000);
        irq_src[4] = 1'b0;
        tick();

        // 4: byte lanes
        io_write(REG_MASK, 16'hABCD, 1'b1, 1'b0);
        io_read(REG_MASK, 16'hAB00);
        io_write(REG_MASK, 16'h1234, 1'b0, 1'b1);
        io_read(REG_MASK, 16'hAB34);
        io_write(REG_MASK, 16'hABCD, 1'b0, 1'b0);
        io_read(REG_MASK, 16'hABCD);
        io_write(REG_MASK, 16'h0000);

        // 5: EOI outside REQ, SWI during REQ
        io_read(REG_STAT, 16'h0009);
        io_write(REG_EOI, 16'h0000);
        io_read(REG_STAT, 16'h0009);
        chk("idle_eoi_rq", int_rq, 0);
        io_write(REG_MASK, 16'hFFFF);
        exp_rise(5, cyc + 2);
        io_write(REG_SWI, 16'h0020);
        wait_rise();
        io_write(REG_SWI, 16'h0001);
        io_read(REG_PEND, 16'h0001);
        io_read(REG_STAT, 16'h8005);
        exp_rise(0, cyc + GAP + 1);
        io_write(REG_EOI, 16'h0000);
        wait_rise();
        io_read(REG_STAT, 16'h8000);
        io_write(REG_EOI, 16'h0000);
        tick(4);

        // 6: asynchronous reset mid-request
        exp_rise(6, cyc + 2);
        io_write(REG_SWI, 16'h0040);
        wait_rise();
        io_read(REG_STAT, 16'h8006);
        chk("pre_rst_rq", int_rq, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_rq", int_rq, 0);
        chk("async_rst_addr", {28'h0, int_addr}, 0);
        tick(2);
        reset_n = 1'b1;
        tick();
        io_read(REG_PEND, 16'h0000);
        io_read(REG_MASK, 16'h0000);
        io_read(REG_STAT, 16'h0000);
        tick(2);

        chk("rd_q_empty", rd_q.size(), 0);
        chk("rise_q_empty", rise_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
